// File: rtl/ps2_key_decoder_if.sv
// Bundles the scan-code input and the event FIFO / held-key outputs of ps2_key_decoder.
// master = PS2 source plus processor/VGA side; slave = decoder.
interface ps2_key_decoder_if #(
  parameter int PTR_W = 3
);
  logic [7:0]     key_data;
  logic           key_valid;
  logic [4:0]     held_keys;
  logic           ev_valid;
  logic [7:0]     ev_data;
  logic           ev_read;
  logic [PTR_W:0] ev_count;
  logic           ev_overflow;
  logic           clr_overflow;

  modport master (
    output key_data, key_valid, ev_read, clr_overflow,
    input  held_keys, ev_valid, ev_data, ev_count, ev_overflow
  );

  modport slave (
    input  key_data, key_valid, ev_read, clr_overflow,
    output held_keys, ev_valid, ev_data, ev_count, ev_overflow
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: E0/F0 prefix FSM, held-key vector for arrows and space,
// and a show-ahead press/release event FIFO with sticky overflow.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input logic            clock,
  input logic            resetn,
  ps2_key_decoder_if.slave bus
);

  localparam logic [PTR_W:0] L_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  // Returns {mapped, key_id}; unmapped codes return 4'h0.
  function automatic logic [3:0] map_key(input logic ext, input logic [7:0] code);
    logic [3:0] m;
    m = 4'h0;
    if (ext) begin
      case (code)
        8'h75:   m = 4'b1_000;
        8'h72:   m = 4'b1_001;
        8'h6B:   m = 4'b1_010;
        8'h74:   m = 4'b1_011;
        default: m = 4'h0;
      endcase
    end else begin
      case (code)
        8'h29:   m = 4'b1_100;
        default: m = 4'h0;
      endcase
    end
    return m;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_dec_en;
  logic             w_dec_ext;
  logic             w_dec_brk;
  logic [3:0]       w_map;
  logic [2:0]       w_id;
  logic             w_push;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic [4:0]       w_held_nxt;
  logic [PTR_W:0]   w_count_nxt;
  logic [7:0]       w_event;

  logic [4:0]       r_held;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ev_valid;
  logic             r_overflow;

  // Prefix state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prefix next-state and decode strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_dec_en    = 1'b0;
    w_dec_ext   = 1'b0;
    w_dec_brk   = 1'b0;
    if (bus.key_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.key_data == 8'hE0) begin
            w_state_nxt = ST_EXT;
          end else if (bus.key_data == 8'hF0) begin
            w_state_nxt = ST_BRK;
          end else begin
            w_dec_en    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (bus.key_data == 8'hF0) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (bus.key_data == 8'hE0) begin
            w_state_nxt = ST_EXT;
          end else begin
            w_dec_en    = 1'b1;
            w_dec_ext   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_dec_en    = 1'b1;
          w_dec_brk   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_dec_en    = 1'b1;
          w_dec_ext   = 1'b1;
          w_dec_brk   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Key lookup, held-key update and FIFO push/pop arbitration.
  always_comb begin
    w_map      = map_key(w_dec_ext, bus.key_data);
    w_id       = w_map[2:0];
    w_push     = 1'b0;
    w_held_nxt = r_held;
    // Typematic repeats and stray breaks leave the held bit as-is and emit nothing.
    if (w_dec_en && w_map[3] && (r_held[w_id] == w_dec_brk)) begin
      w_push             = 1'b1;
      w_held_nxt[w_id]   = ~w_dec_brk;
    end else begin
      w_push             = 1'b0;
    end
    w_event   = {w_dec_brk, 4'b0000, w_id};
    w_pop     = bus.ev_read && (r_count != {(PTR_W + 1){1'b0}});
    w_push_ok = w_push && ((r_count != L_DEPTH) || w_pop);
    w_drop    = w_push && !w_push_ok;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_nxt = r_count + {{PTR_W{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{PTR_W{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // Held keys, FIFO storage, pointers, count and overflow flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_held     <= 5'b00000;
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {(PTR_W + 1){1'b0}};
      r_ev_valid <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      r_held     <= w_held_nxt;
      r_count    <= w_count_nxt;
      r_ev_valid <= (w_count_nxt != {(PTR_W + 1){1'b0}});
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_event;
        r_wr_ptr        <= r_wr_ptr + {{(PTR_W - 1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(PTR_W - 1){1'b0}}, 1'b1};
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.held_keys   = r_held;
  assign bus.ev_valid    = r_ev_valid;
  assign bus.ev_count    = r_count;
  assign bus.ev_overflow = r_overflow;
  assign bus.ev_data     = r_ev_valid ? r_mem[r_rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random byte
// streams compared every cycle against a queue-based behavioural model.
module tb_ps2_key_decoder;

  logic clock;
  logic resetn;

  ps2_key_decoder_if #(.PTR_W(3)) bus ();

  ps2_key_decoder #(.FIFO_DEPTH(8), .PTR_W(3)) u_dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  bit       m_ext;
  bit       m_brk;
  bit [4:0] m_held;
  bit       m_ovf;
  logic [7:0] m_q[$];

  logic [7:0] rnd_bytes [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B,
                                 8'h74, 8'h29, 8'h12, 8'h1C, 8'hFA};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int key_id(input bit ext, input logic [7:0] code);
    if (ext && code == 8'h75) return 0;
    if (ext && code == 8'h72) return 1;
    if (ext && code == 8'h6B) return 2;
    if (ext && code == 8'h74) return 3;
    if (!ext && code == 8'h29) return 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_held = 5'b0;
    m_ovf  = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input logic kv, input logic [7:0] kd, input logic rd, input logic clr);
    bit         have_ev;
    bit         pop;
    int         id;
    logic [7:0] ev;
    have_ev = 1'b0;
    ev      = 8'h00;
    pop     = rd && (m_q.size() > 0);
    if (kv) begin
      if (!m_brk && kd == 8'hE0) begin
        m_ext = 1'b1;
      end else if (!m_brk && kd == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        id = key_id(m_ext, kd);
        if (id >= 0) begin
          if (!m_brk && !m_held[id]) begin
            m_held[id] = 1'b1;
            have_ev    = 1'b1;
            ev         = 8'(id);
          end else if (m_brk && m_held[id]) begin
            m_held[id] = 1'b0;
            have_ev    = 1'b1;
            ev         = 8'h80 + 8'(id);
          end
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (have_ev && m_q.size() < 8) begin
      m_q.push_back(ev);
    end else if (have_ev) begin
      m_ovf = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    if (have_ev && m_q.size() <= 8 && clr && m_ovf && !pop && m_q.size() < 8) m_ovf = 1'b0;
  endtask

  task automatic compare_all();
    chk("held_keys",   32'(bus.held_keys),   32'(m_held));
    chk("ev_count",    32'(bus.ev_count),    32'(m_q.size()));
    chk("ev_valid",    32'(bus.ev_valid),    32'(m_q.size() != 0));
    chk("ev_data",     32'(bus.ev_data),     32'((m_q.size() != 0) ? m_q[0] : 8'h00));
    chk("ev_overflow", 32'(bus.ev_overflow), 32'(m_ovf));
  endtask

  task automatic tick(input logic kv, input logic [7:0] kd, input logic rd, input logic clr);
    @(negedge clock);
    bus.key_valid    = kv;
    bus.key_data     = kd;
    bus.ev_read      = rd;
    bus.clr_overflow = clr;
    @(posedge clock);
    model_step(kv, kd, rd, clr);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.key_valid    = 1'b0;
    bus.key_data     = 8'h00;
    bus.ev_read      = 1'b0;
    bus.clr_overflow = 1'b0;
    resetn           = 1'b0;
    model_reset();
    #2;
    chk("rst_held",  32'(bus.held_keys),   32'h0);
    chk("rst_valid", 32'(bus.ev_valid),    32'h0);
    chk("rst_data",  32'(bus.ev_data),     32'h0);
    chk("rst_count", 32'(bus.ev_count),    32'h0);
    chk("rst_ovf",   32'(bus.ev_overflow), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    resetn           = 1'b0;
    bus.key_valid    = 1'b0;
    bus.key_data     = 8'h00;
    bus.ev_read      = 1'b0;
    bus.clr_overflow = 1'b0;
    model_reset();
    do_reset();

    // Extended up press and release.
    send(8'hE0); send(8'h75);
    chk("up_held", 32'(bus.held_keys), 32'h01);
    chk("up_data", 32'(bus.ev_data),   32'h00);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_cnt", 32'(bus.ev_count), 32'd2);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("up_rel", 32'(bus.ev_data), 32'h80);
    tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Typematic space.
    send(8'h29); send(8'h29); send(8'h29);
    chk("sp_held", 32'(bus.held_keys), 32'h10);
    send(8'hF0); send(8'h29);
    chk("sp_cnt", 32'(bus.ev_count), 32'd2);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Stray break and unmapped extended codes, then left press.
    send(8'hF0); send(8'h29); send(8'hE0); send(8'h12); send(8'h1C);
    chk("unm_cnt", 32'(bus.ev_count), 32'd0);
    send(8'hE0); send(8'h6B);
    chk("left_data", 32'(bus.ev_data), 32'h02);

    // Overflow: nine events with no reads.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(8'hE0); send(8'h75 - 8'(k == 1 ? 3 : 0) - 8'(k == 2 ? 10 : 0) - 8'(k == 3 ? 1 : 0));
      send(8'hE0); send(8'hF0); send(8'h75 - 8'(k == 1 ? 3 : 0) - 8'(k == 2 ? 10 : 0) - 8'(k == 3 ? 1 : 0));
    end
    send(8'h29);
    chk("ovf_cnt",  32'(bus.ev_count),    32'd8);
    chk("ovf_flag", 32'(bus.ev_overflow), 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.ev_overflow), 32'd0);
    send(8'hF0);
    tick(1'b1, 8'h29, 1'b1, 1'b0);
    chk("full_rw_cnt", 32'(bus.ev_count),    32'd8);
    chk("full_rw_ovf", 32'(bus.ev_overflow), 32'd0);

    // Reset discards a pending E0.
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h74);
    chk("rst_pfx_cnt",  32'(bus.ev_count),  32'd0);
    chk("rst_pfx_held", 32'(bus.held_keys), 32'h0);

    // Random stream with sparse reads so the FIFO fills and overflows.
    for (int c = 0; c < 1500; c++) begin
      tick(1'($urandom_range(0, 2) != 0), rnd_bytes[$urandom_range(0, 9)],
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 31) == 0));
    end
    // Random stream with a read every cycle.
    for (int c = 0; c < 1500; c++) begin
      tick(1'($urandom_range(0, 3) != 0), rnd_bytes[$urandom_range(0, 9)],
           1'b1, 1'($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Decodes the raw PS/2 scan-code byte stream from `PS2_Interface` into game-control state. It tracks make/break and E0-extended prefixes, maintains a live held-key vector for the arrow keys and space, and queues press/release events in a show-ahead FIFO. The FIFO is drained by the processor's memory-mapped input path; `held_keys` feeds `vga_controller` directly. It sits between `PS2_Interface` (upstream) and the processor/VGA consumers (downstream).

## Interface
- `FIFO_DEPTH`, 8, event FIFO entries; power of two, ≥2
- `PTR_W`, 3, log2(FIFO_DEPTH)
- `clock`  in  1  system clock (the same `clock` that drives `PS2_Interface`)
- `resetn`  in  1  reset, asynchronous, active-low
- `key_data`  in  8  scan-code byte from `PS2_Interface`
- `key_valid`  in  1  one-cycle strobe; `key_data` is valid when high
- `held_keys`  out  5  {space, right, left, down, up}; 1 = currently held
- `ev_valid`  out  1  FIFO non-empty
- `ev_data`  out  8  head event: [7] = release flag, [6:3] = 0, [2:0] = key id (0 up, 1 down, 2 left, 3 right, 4 space)
- `ev_read`  in  1  pop head event; ignored when `ev_valid` = 0
- `ev_count`  out  PTR_W+1  entries in the FIFO, 0..FIFO_DEPTH
- `ev_overflow`  out  1  sticky; set when an event is dropped
- `clr_overflow`  in  1  synchronous clear of `ev_overflow`

## Operation
- Prefix FSM has four states: IDLE, EXT (E0 seen), BRK (F0 seen), and EXT_BRK (E0 F0 seen). It advances only on cycles where `key_valid` = 1.
- IDLE: E0 → EXT; F0 → BRK; any other byte is decoded as a non-extended make, then the FSM stays in IDLE.
- EXT: F0 → EXT_BRK; E0 → stays in EXT; any other byte is decoded as an extended make, then → IDLE.
- BRK: the byte is decoded as a non-extended break, then → IDLE. EXT_BRK: the byte is decoded as an extended break, then → IDLE.
- Key map:
  - extended 75 = up, 72 = down, 6B = left, 74 = right
  - non-extended 29 = space
  - all other codes (including FA, AA, E1 and their trailing bytes) are unmapped: no event and no state change beyond the FSM transition.
- Make of a mapped key:
  - if its `held_keys` bit is 0, set the bit and push a press event (bit7 = 0)
  - if the bit is already 1 (typematic repeat), do nothing.
- Break of a mapped key:
  - if its bit is 1, clear the bit and push a release event (bit7 = 1)
  - if the bit is already 0, do nothing.
- FIFO push and pop:
  - A push is accepted when `ev_count` < FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and `ev_overflow` is set. `held_keys` still updates.
  - Simultaneous accepted push and pop: `ev_count` is unchanged, head advances, new entry is written at tail.
  - Pointers are PTR_W bits and wrap modulo FIFO_DEPTH.
- `ev_overflow`: if set and clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - FSM = IDLE
  - `held_keys` = 0, `ev_valid` = 0, `ev_data` = 00, `ev_count` = 0, `ev_overflow` = 0
  - both FIFO pointers = 0.
- Assertion of `resetn` mid-sequence (for example, after an E0) discards the prefix. FIFO contents are lost.
- Latency: a final byte strobed in cycle n updates `held_keys`, `ev_count` and `ev_valid` at the clock edge ending cycle n. The results are visible in cycle n+1.
- `ev_data` is show-ahead: it is combinational from the FIFO head, valid whenever `ev_valid` = 1, and reads as 00 when the FIFO is empty.
- `ev_read` in cycle n: the next entry (or empty) is presented in cycle n+1.
- `key_valid` may be asserted on back-to-back cycles. Every strobe is consumed; no backpressure is applied to `PS2_Interface`.
- All outputs are registered except `ev_data`, which is a registered FIFO memory word selected by the registered head pointer.

## Test plan
- Reset, then E0 75 → `held_keys` = 00001, `ev_count` = 1, `ev_data` = 00. Then E0 F0 75 → `held_keys` = 0, second event = 80.
- 29, 29, 29 (typematic), then F0 29 → exactly two events: 04 and 84. `held_keys[4]` is high between them.
- F0 29 with space not held, and E0 12 / 1C (unmapped) → no events, `held_keys` = 0, FSM back in IDLE; a following E0 6B yields event 02.
- Nine distinct press/release events with no reads (FIFO_DEPTH = 8) → `ev_count` = 8, ninth dropped, `ev_overflow` = 1. Then `clr_overflow` → 0. Full FIFO with push and `ev_read` in the same cycle → count stays 8, new event is stored.
- E0 in flight, then `resetn` pulsed low, then 74 → no event (byte decoded as non-extended, unmapped), `held_keys` = 0.
- Interleaved `ev_read` on every cycle with back-to-back `key_valid` bytes → events are popped in arrival order, with no loss or duplication and no pop when the FIFO is empty.
